// File: rtl/seg_scan_ctrl_if.sv
// Bundle between the display scan scheduler and its surroundings: the two
// display sources with their select/hold controls, and the scan outputs that
// feed the anode drivers and the hex-to-segment decoder.
interface seg_scan_ctrl_if;
    logic [15:0] value_a;      // display source 0
    logic [15:0] value_b;      // display source 1
    logic        sel_b;        // 1 selects value_b at the capture edge
    logic        hold;         // 1 keeps the latched value at the capture edge
    logic [3:0]  enable;       // active-low anode enables
    logic [3:0]  digit_nibble; // nibble of the addressed digit
    logic [1:0]  digit_idx;    // digit currently addressed
    logic        frame_done;   // one-cycle pulse after each capture edge
    logic        blanking;     // 1 while in the inter-digit gap

    // Side that supplies the sources and consumes the scan outputs
    modport master (
        output value_a, value_b, sel_b, hold,
        input  enable, digit_nibble, digit_idx, frame_done, blanking
    );

    // Scan scheduler side
    modport slave (
        input  value_a, value_b, sel_b, hold,
        output enable, digit_nibble, digit_idx, frame_done, blanking
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// Alternates a BLANK gap (all anodes off) and a SHOW phase per digit. The
// displayed 16-bit value is latched only when digit 3 hands over to digit 0,
// so a frame never mixes two source values.
// Optional feature: define SEG_LZB_EN for leading-zero blanking (upper digits
// whose value and everything above them are zero stay dark; digit 0 always lit).
module seg_scan_ctrl #(
    parameter int unsigned DIV   = 50000, // SHOW length per digit in clocks, >= 2
    parameter int unsigned BLANK = 4      // gap length between digits in clocks, >= 1
) (
    input logic            internal_clk,
    input logic            rst_n,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW = (BLANK > 1) ? $clog2(BLANK) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLANK - 1);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e        state_q;
    logic [BW-1:0] bcnt_q;
    logic [PW-1:0] pcnt_q;
    logic [1:0]    idx_q;
    logic [15:0]   latched_q;
    logic [3:0]    enable_q;
    logic          frame_done_q;
    logic          blanking_q;

    logic [1:0]    idx_next;
    logic          capture;
    logic [15:0]   latched_next;
    logic [3:0]    enable_next;

    // Values loaded at the BLANK->SHOW edge: next digit, capture decision, anode pattern
    always_comb begin
        idx_next     = idx_q + 2'd1;
        // Wrapping 3 -> 0 is the frame boundary
        capture      = (idx_q == 2'd3);
        latched_next = latched_q;
        if (capture && !bus.hold) begin
            latched_next = bus.sel_b ? bus.value_b : bus.value_a;
        end
        enable_next  = ~(4'b0001 << idx_next);
`ifdef SEG_LZB_EN
        // Uses the value that will be latched, so a digit never lights from stale data
        unique case (idx_next)
            2'd1:    if (latched_next[15:4]  == 12'h000) enable_next = 4'b1111;
            2'd2:    if (latched_next[15:8]  == 8'h00)   enable_next = 4'b1111;
            2'd3:    if (latched_next[15:12] == 4'h0)    enable_next = 4'b1111;
            default: ;
        endcase
`endif
    end

    // Scan FSM: counters, digit sequencing, frame capture and registered outputs
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            bcnt_q       <= '0;
            pcnt_q       <= '0;
            idx_q        <= 2'd3;
            latched_q    <= 16'h0000;
            enable_q     <= 4'b1111;
            frame_done_q <= 1'b0;
            blanking_q   <= 1'b1;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StBlank: begin
                    if (bcnt_q == BCNT_LAST) begin
                        state_q    <= StShow;
                        bcnt_q     <= '0;
                        idx_q      <= idx_next;
                        enable_q   <= enable_next;
                        blanking_q <= 1'b0;
                        if (capture) begin
                            frame_done_q <= 1'b1;
                            latched_q    <= latched_next;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + BCNT_ONE;
                    end
                end
                StShow: begin
                    if (pcnt_q == PCNT_LAST) begin
                        state_q    <= StBlank;
                        pcnt_q     <= '0;
                        enable_q   <= 4'b1111;
                        blanking_q <= 1'b1;
                    end else begin
                        pcnt_q <= pcnt_q + PCNT_ONE;
                    end
                end
                default: begin
                    state_q    <= StBlank;
                    enable_q   <= 4'b1111;
                    blanking_q <= 1'b1;
                end
            endcase
        end
    end

    // Decoder feed follows the addressed digit in both phases
    always_comb begin
        bus.digit_nibble = latched_q[{idx_q, 2'b00} +: 4];
    end

    assign bus.enable     = enable_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.blanking   = blanking_q;

`ifndef SYNTHESIS
    // Two anodes on together would short two digits onto the same segments
    a_one_anode: assert property (@(posedge internal_clk) disable iff (!rst_n)
        $countones(~enable_q) <= 1);
`endif

endmodule
